uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART output stream among NUM_SRC byte-wide AXI4-Stream sources. Candidate sources are TCP rest-of-frame, Ethernet PHY frames-out and app/brain status. Each forwarded data byte is preceded by its source's 8-bit type header, preserving the existing header+byte UART framing. A source may hold the grant for a burst of up to MAX_BURST bytes, or until its tlast, before the pointer rotates. The block sits between the source streams and the UART transmitter, replacing fixed-priority polling.

## Interface
- DATA_WIDTH, 8, byte width of every stream (header width is fixed at 8; DATA_WIDTH must equal 8)
- NUM_SRC, 3, number of requesting sources (2..8)
- MAX_BURST, 16, maximum data bytes per grant (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- src_tdata  in  NUM_SRC*DATA_WIDTH  source data; slice i = bits [i*8 +: 8]
- src_tvalid  in  NUM_SRC  per-source valid
- src_tready  out  NUM_SRC  per-source ready
- src_tlast  in  NUM_SRC  per-source end of message
- src_header  in  NUM_SRC*8  static type code per source; sampled at HDR
- uart_out_tdata  out  8  header or data byte to the UART transmitter
- uart_out_tvalid  out  1  output valid
- uart_out_tready  in  1  output ready
- uart_out_tlast  out  1  high on the last data byte of a grant
- grant  out  NUM_SRC  one-hot current grantee; zero in IDLE
- busy  out  1  high in HDR or DATA

## Operation
- Registered state: `state`, `gnt_idx`, `last_idx` (rotation pointer), `burst_cnt` (8 bit) and `hold`.
- States are IDLE, HDR and DATA.
- IDLE, arbitration:
  - If `hold`=1 and src_tvalid[last_idx]=1, re-grant last_idx.
  - Otherwise grant the first i with src_tvalid[i]=1, scanning last_idx+1, last_idx+2, … mod NUM_SRC.
  - If `hold`=1 but the source is not valid, clear `hold` and `burst_cnt` and arbitrate round-robin in the same cycle.
  - Any grant goes to HDR. If no source is valid, stay in IDLE.
- HDR:
  - uart_out_tdata = src_header[gnt_idx], uart_out_tvalid=1, uart_out_tlast=0, all src_tready=0.
  - On handshake go to DATA.
- DATA, combinational pass-through:
  - uart_out_tdata = src_tdata[gnt_idx], uart_out_tvalid = src_tvalid[gnt_idx], src_tready[gnt_idx] = uart_out_tready; other readies are 0.
  - end = src_tlast[gnt_idx] OR burst_cnt == MAX_BURST-1.
  - uart_out_tlast = end AND uart_out_tvalid.
- DATA handshake, always:
  - last_idx←gnt_idx; go to IDLE.
- DATA handshake with end=1:
  - hold←0, burst_cnt←0.
- DATA handshake with end=0:
  - hold←1, burst_cnt←burst_cnt+1.
- Every data byte is header-prefixed, including consecutive bytes within a burst.
- Never accept a source byte in IDLE or HDR; src_tready is 0 there.

## Timing
- Reset values:
  - Registers: state=IDLE, last_idx=NUM_SRC-1 (so source 0 wins first), gnt_idx=0, hold=0, burst_cnt=0.
  - Outputs: uart_out_tvalid=0, uart_out_tdata=0, uart_out_tlast=0, src_tready=0, grant=0, busy=0.
- Latency: a request seen in IDLE in cycle N gives header valid in N+1. The earliest data handshake is N+2.
- Peak rate: 1 data byte per 3 cycles.
- Output back-pressure: uart_out_tvalid, once high, stays high with stable tdata until the handshake, in both HDR and DATA. Sources must obey AXI and hold tvalid/tdata once asserted.
- Simultaneous requests resolve purely by rotation; a burst holder beats others only while `hold`=1.
- MAX_BURST=1: end is always 1, so the pointer rotates every byte.
- burst_cnt never exceeds MAX_BURST-1; there is no wrap.
- Reset mid-operation returns to IDLE on the next edge. A header already sent without its data byte is tolerated; the host resyncs on header codes.

## Structure
- Shared package `uart_mux_pkg`:
  - Header codes: PARROT=0, ETH_FRAME_IN=1, ETH_FRAME_OUT=2, REMAINING_LAYER=3, INSTRUCTION=4, BRAIN_STATUS=5, PAYLOAD_COMING=6, INFO=7.
  - The arbiter state encoding, as localparams.
- One sub-module, `rr_pick`: combinational, with inputs req[NUM_SRC] and last_idx, outputs found and idx. Reusable for the RX-side dispatcher.

## Test plan
- Single source: reset, then src1 (header 0x02) sends 0xAB with tlast. Expect out 0x02, 0xAB; tlast on 0xAB; grant=3'b010 for 2 beats; then IDLE.
- Rotation: all three sources are valid continuously with tlast on every byte, headers 3/2/5. Expect header order 3, 2, 5, 3, 2, 5 starting at src0.
- Burst cap: MAX_BURST=4, src0 streams 10 bytes 0x10..0x19 with no tlast and src2 is valid. Expect 0x10..0x13 each header-prefixed, tlast on 0x13, then src2, then src0 resumes at 0x14.
- Back-pressure: uart_out_tready is low for 5 cycles in HDR and again in DATA. Expect tdata and tvalid stable, src_tready low in HDR, and no duplicated or lost byte.
- Hold release: src0 drops tvalid after 2 of 4 burst bytes while src1 is valid. Expect src1 granted next; hold and burst_cnt cleared.
- Reset mid-DATA: assert rst_n=0 while a byte is pending. Next cycle all outputs are 0 and state is IDLE; after release, src0 is first.

Source files
------------

// File: rtl/uart_mux_pkg.sv
// Shared definitions for the UART stream multiplexer: header type codes,
// arbiter state encoding and a pointer-width helper.
package uart_mux_pkg;

    localparam logic [7:0] HDR_PARROT          = 8'd0;
    localparam logic [7:0] HDR_ETH_FRAME_IN    = 8'd1;
    localparam logic [7:0] HDR_ETH_FRAME_OUT   = 8'd2;
    localparam logic [7:0] HDR_REMAINING_LAYER = 8'd3;
    localparam logic [7:0] HDR_INSTRUCTION     = 8'd4;
    localparam logic [7:0] HDR_BRAIN_STATUS    = 8'd5;
    localparam logic [7:0] HDR_PAYLOAD_COMING  = 8'd6;
    localparam logic [7:0] HDR_INFO            = 8'd7;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_HDR  = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_HDR  = ARB_HDR,
        ST_DATA = ARB_DATA
    } arb_state_t;

    // Width of a source index; at least one bit even for a single source.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// last_idx+1, last_idx+2, ... modulo NUM_SRC.
module rr_pick
    import uart_mux_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0]   cand [NUM_SRC];
    logic [NUM_SRC-1:0] cand_req;

    // Candidate gi is the source gi+1 places after the pointer; the sum stays
    // below 2*NUM_SRC so a single conditional subtract gives the modulo.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum          = {1'b0, last_idx} + (IDX_W+1)'(gi + 1);
        assign cand[gi]     = (sum >= (IDX_W+1)'(NUM_SRC)) ?
                              IDX_W'(sum - (IDX_W+1)'(NUM_SRC)) : IDX_W'(sum);
        assign cand_req[gi] = req[cand[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte stream among NUM_SRC AXI4-Stream
// sources; every forwarded data byte is preceded by its source's header.
module uart_tx_arbiter
    import uart_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 3,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC-1:0]            src_tlast,
    input  logic [NUM_SRC*8-1:0]          src_header,
    output logic [7:0]                    uart_out_tdata,
    output logic                          uart_out_tvalid,
    input  logic                          uart_out_tready,
    output logic                          uart_out_tlast,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy
);

    localparam int         IDX_W      = idx_width(NUM_SRC);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic             hold_q, hold_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       hdr_sel;
    logic [7:0]       data_sel;
    logic             tvalid_sel;
    logic             tlast_sel;
    logic             end_beat;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (src_tvalid),
        .last_idx (last_idx_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign hdr_sel    = src_header[{gnt_idx_q, 3'b000} +: 8];
    assign data_sel   = src_tdata[{gnt_idx_q, 3'b000} +: DATA_WIDTH];
    assign tvalid_sel = src_tvalid[gnt_idx_q];
    assign tlast_sel  = src_tlast[gnt_idx_q];
    assign end_beat   = tlast_sel || (burst_cnt_q == BURST_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= '0;
            last_idx_q  <= IDX_W'(NUM_SRC - 1);
            burst_cnt_q <= '0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
            burst_cnt_q <= burst_cnt_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_idx_d       = gnt_idx_q;
        last_idx_d      = last_idx_q;
        burst_cnt_d     = burst_cnt_q;
        hold_d          = hold_q;
        uart_out_tdata  = '0;
        uart_out_tvalid = 1'b0;
        uart_out_tlast  = 1'b0;
        src_tready      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_q && src_tvalid[last_idx_q]) begin
                    gnt_idx_d = last_idx_q;
                    state_d   = ST_HDR;
                end else begin
                    // A stalled burst holder forfeits its remaining burst.
                    if (hold_q) begin
                        hold_d      = 1'b0;
                        burst_cnt_d = '0;
                    end
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                uart_out_tdata  = hdr_sel;
                uart_out_tvalid = 1'b1;
                if (uart_out_tready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                uart_out_tdata        = data_sel;
                uart_out_tvalid       = tvalid_sel;
                uart_out_tlast        = end_beat && tvalid_sel;
                src_tready[gnt_idx_q] = uart_out_tready;
                if (tvalid_sel && uart_out_tready) begin
                    last_idx_d = gnt_idx_q;
                    state_d    = ST_IDLE;
                    if (end_beat) begin
                        hold_d      = 1'b0;
                        burst_cnt_d = '0;
                    end else begin
                        hold_d      = 1'b1;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_grant
        assign grant[gi] = (state_q != ST_IDLE) && (gnt_idx_q == IDX_W'(gi));
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// rounds, checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*8-1:0] src_tdata;
    logic [N-1:0]   src_tvalid;
    logic [N-1:0]   src_tready;
    logic [N-1:0]   src_tlast;
    logic [N*8-1:0] src_header;
    logic [7:0]     uart_out_tdata;
    logic           uart_out_tvalid;
    logic           uart_out_tready;
    logic           uart_out_tlast;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH (8),
        .NUM_SRC    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_tdata       (src_tdata),
        .src_tvalid      (src_tvalid),
        .src_tready      (src_tready),
        .src_tlast       (src_tlast),
        .src_header      (src_header),
        .uart_out_tdata  (uart_out_tdata),
        .uart_out_tvalid (uart_out_tvalid),
        .uart_out_tready (uart_out_tready),
        .uart_out_tlast  (uart_out_tlast),
        .grant           (grant),
        .busy            (busy)
    );

    typedef struct packed {
        logic       is_hdr;
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] sbuf [N][256];
    int         wr [N];
    int         rd [N];
    int         mrd [N];
    logic [7:0] hdr_code [N];
    int         m_last;
    bit         m_hold;
    int         m_cnt;
    int         total = 0;
    int         bad = 0;
    int         tr_mode;
    int         stall_cnt;
    bit         prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        sbuf[s][wr[s]] = {l, d};
        wr[s]++;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (rd[i] < wr[i]) p = 1'b1;
        return p;
    endfunction

    // Transaction-level arbitration: replay every loaded byte in grant order.
    task automatic gen_model();
        forever begin
            bit   any = 1'b0;
            bit   fnd = 1'b0;
            int   s = 0;
            logic [8:0] b;
            bit   e;
            for (int i = 0; i < N; i++) if (mrd[i] < wr[i]) any = 1'b1;
            if (!any) break;
            if (m_hold && mrd[m_last] < wr[m_last]) begin
                s = m_last;
            end else begin
                m_hold = 1'b0;
                m_cnt  = 0;
                for (int k = 1; k <= N; k++) begin
                    int c = (m_last + k) % N;
                    if (!fnd && mrd[c] < wr[c]) begin
                        s   = c;
                        fnd = 1'b1;
                    end
                end
            end
            b = sbuf[s][mrd[s]];
            mrd[s]++;
            e = b[8] || (m_cnt == MB - 1);
            exp_q.push_back('{1'b1, 2'(s), hdr_code[s], 1'b0});
            exp_q.push_back('{1'b0, 2'(s), b[7:0], e});
            m_last = s;
            if (e) begin
                m_hold = 1'b0;
                m_cnt  = 0;
            end else begin
                m_hold = 1'b1;
                m_cnt++;
            end
        end
    endtask

    task automatic step();
        bit hs;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            src_tvalid[i]       = (rd[i] < wr[i]);
            src_tdata[i*8 +: 8] = src_tvalid[i] ? sbuf[i][rd[i]][7:0] : 8'h00;
            src_tlast[i]        = src_tvalid[i] ? sbuf[i][rd[i]][8] : 1'b0;
        end
        #1;
        case (tr_mode)
            0:       uart_out_tready = 1'b1;
            1:       uart_out_tready = ($urandom_range(0, 9) < 7);
            2:       uart_out_tready = !(uart_out_tvalid && stall_cnt < 5);
            default: uart_out_tready = 1'b0;
        endcase
        #1;
        if (prev_stall) begin
            check("stall_tvalid", 32'(uart_out_tvalid), 32'd1);
            check("stall_tdata", 32'(uart_out_tdata), 32'(prev_data));
        end
        hs = uart_out_tvalid && uart_out_tready;
        if (hs) begin
            stall_cnt = 0;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                beat_t e = exp_q.pop_front();
                $display("beat %s src=%0d data=%02h last=%0d", e.is_hdr ? "hdr " : "data",
                         e.src, uart_out_tdata, uart_out_tlast);
                check(e.is_hdr ? "hdr_byte" : "data_byte", 32'(uart_out_tdata), 32'(e.data));
                check("out_tlast", 32'(uart_out_tlast), 32'(e.last));
                check("src_tready", 32'(src_tready), e.is_hdr ? 32'd0 : (32'd1 << e.src));
                check("grant", 32'(grant), 32'd1 << e.src);
            end
        end else if (uart_out_tvalid) begin
            stall_cnt++;
        end
        for (int i = 0; i < N; i++) if (src_tvalid[i] && src_tready[i]) rd[i]++;
        prev_stall = uart_out_tvalid && !uart_out_tready;
        prev_data  = uart_out_tdata;
        @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || pending()) && n < 2000) begin
            step();
            n++;
        end
        check("drain_done", 32'(exp_q.size() == 0 && !pending()), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        src_tvalid      = '0;
        src_tdata       = '0;
        src_tlast       = '0;
        uart_out_tready = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr[i]  = 0;
            rd[i]  = 0;
            mrd[i] = 0;
        end
        exp_q.delete();
        m_last     = N - 1;
        m_hold     = 1'b0;
        m_cnt      = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(uart_out_tvalid), 32'd0);
        check("rst_tdata", 32'(uart_out_tdata), 32'd0);
        check("rst_tlast", 32'(uart_out_tlast), 32'd0);
        check("rst_src_tready", 32'(src_tready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        hdr_code[0] = 8'h03;
        hdr_code[1] = 8'h02;
        hdr_code[2] = 8'h05;
        for (int i = 0; i < N; i++) src_header[i*8 +: 8] = hdr_code[i];
        tr_mode = 0;
        do_reset();

        // Single source with header latency
        push(1, 8'hAB, 1'b1);
        gen_model();
        step();
        #1;
        check("lat_hdr_tvalid", 32'(uart_out_tvalid), 32'd1);
        check("lat_hdr_tdata", 32'(uart_out_tdata), 32'h02);
        check("lat_hdr_grant", 32'(grant), 32'b010);
        drain();
        step();
        step();
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tvalid", 32'(uart_out_tvalid), 32'd0);

        // Rotation with tlast on every byte
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(8'h40 + r * 8 + i), 1'b1);
        gen_model();
        drain();

        // Burst cap under back-pressure
        do_reset();
        for (int k = 0; k < 10; k++) push(0, 8'(8'h10 + k), 1'b0);
        push(2, 8'hEE, 1'b1);
        gen_model();
        tr_mode = 2;
        drain();

        // Hold release: src0 runs dry mid-burst while src1 waits
        do_reset();
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(1, 8'hB0, 1'b0);
        push(1, 8'hB1, 1'b0);
        gen_model();
        tr_mode = 1;
        drain();
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b0);
        gen_model();
        drain();

        // Randomized rounds
        do_reset();
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < N; i++) begin
                int len = $urandom_range(0, 5);
                for (int k = 0; k < len; k++)
                    push(i, 8'($urandom), ($urandom_range(0, 2) == 0));
            end
            gen_model();
            tr_mode = 1;
            drain();
        end

        // Reset while a data byte is pending
        do_reset();
        push(0, 8'h5A, 1'b1);
        gen_model();
        tr_mode = 0;
        step();
        step();
        tr_mode = 3;
        step();
        #1;
        check("mid_tvalid", 32'(uart_out_tvalid), 32'd1);
        check("mid_tdata", 32'(uart_out_tdata), 32'h5A);
        check("mid_src_tready", 32'(src_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tvalid", 32'(uart_out_tvalid), 32'd0);
        check("midrst_tdata", 32'(uart_out_tdata), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        do_reset();
        push(1, 8'h61, 1'b1);
        push(0, 8'h60, 1'b1);
        gen_model();
        tr_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
